// File: rtl/serial_adder.sv
// Bit-serial adder: a single full_adder cell consumes one operand bit pair per
// clock, LSB first, with the carry held in a flip-flop between cycles.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic            cy;
    logic [CW-1:0]   cnt;
    logic            fa_sum;
    logic            fa_carry;

    full_adder u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c     (cy),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // The sum register and carry flop double as the result holding registers,
    // so the outputs stay frozen in DONE without any extra storage.
    assign sum_out   = s_sr;
    assign carry_out = cy;

    // Handshake flags are registered alongside the state so neither ready nor
    // valid ever depends combinationally on the opposite side's inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            s_sr      <= '0;
            cy        <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr     <= a_in;
                        b_sr     <= b_in;
                        cy       <= c_in;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    s_sr <= {fa_sum, s_sr[WIDTH-1:1]};
                    a_sr <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    cy   <= fa_carry;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: directed vectors on an 8-bit instance plus
// random streams on 8- and 16-bit instances, checked against a queue model.

module tb_serial_adder;
    logic        clk;
    logic        rst;

    logic        iv8, ir8, ov8, or8, co8, busy8, c8;
    logic [7:0]  a8, b8, s8;

    logic        iv16, ir16, ov16, or16, co16, busy16, c16;
    logic [15:0] a16, b16, s16;

    int total;
    int bad;
    int cycle;

    logic [8:0]  exp8[$];
    int          acc8[$];
    logic [16:0] exp16[$];
    int          acc16[$];
    int          last8, last16;
    logic        prev8, prev16;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a_in(a8), .b_in(b8),
        .c_in(c8), .out_valid(ov8), .out_ready(or8), .sum_out(s8), .carry_out(co8),
        .busy(busy8)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a_in(a16), .b_in(b16),
        .c_in(c16), .out_valid(ov16), .out_ready(or16), .sum_out(s16), .carry_out(co16),
        .busy(busy16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got timeout expected event", name);
    endtask

    // Model for the 8-bit instance: every accepted operand pair becomes an
    // expected WIDTH+1-bit sum, retired when the result handshake completes.
    always @(negedge clk) begin
        if (rst) begin
            exp8.delete();
            acc8.delete();
            last8 = -100000;
            prev8 = 1'b0;
        end else begin
            if (ov8) begin
                if (exp8.size() == 0) begin
                    checkOutput("dut8_spurious_valid", 32'(ov8), 32'(0));
                end else begin
                    checkOutput("dut8_result", 32'({co8, s8}), 32'(exp8[0]));
                    checkOutput("dut8_no_ready_in_done", 32'(ir8), 32'(0));
                    if (!prev8) checkOutput("dut8_latency", 32'(cycle - acc8[0]), 32'(8));
                    if (or8) begin
                        void'(exp8.pop_front());
                        void'(acc8.pop_front());
                    end
                end
            end
            if (iv8 && ir8) begin
                exp8.push_back(9'(a8) + 9'(b8) + 9'(c8));
                acc8.push_back(cycle + 1);
                checkOutput("dut8_interval_ok", 32'((cycle + 1 - last8) >= 10), 32'(1));
                last8 = cycle + 1;
            end
            prev8 = ov8;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp16.delete();
            acc16.delete();
            last16 = -100000;
            prev16 = 1'b0;
        end else begin
            if (ov16) begin
                if (exp16.size() == 0) begin
                    checkOutput("dut16_spurious_valid", 32'(ov16), 32'(0));
                end else begin
                    checkOutput("dut16_result", 32'({co16, s16}), 32'(exp16[0]));
                    if (!prev16) checkOutput("dut16_latency", 32'(cycle - acc16[0]), 32'(16));
                    if (or16) begin
                        void'(exp16.pop_front());
                        void'(acc16.pop_front());
                    end
                end
            end
            if (iv16 && ir16) begin
                exp16.push_back(17'(a16) + 17'(b16) + 17'(c16));
                acc16.push_back(cycle + 1);
                checkOutput("dut16_interval_ok", 32'((cycle + 1 - last16) >= 18), 32'(1));
                last16 = cycle + 1;
            end
            prev16 = ov16;
        end
    end

    task automatic waitOut8(output logic [8:0] res);
        bit seen = 0;
        res = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ov8) begin
                seen = 1;
                break;
            end
        end
        if (seen) res = {co8, s8};
        else failNow("dut8_wait_out_valid");
    endtask

    // Present one operand pair, wait for acceptance, then wait for the result.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c,
                                 output logic [8:0] res, output int lat);
        bit got = 0;
        int accCycle;
        @(posedge clk);
        #1;
        a8 = a; b8 = b; c8 = c; iv8 = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ir8) begin
                got = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        accCycle = cycle;
        if (!got) failNow("dut8_accept");
        waitOut8(res);
        lat = cycle - accCycle;
    endtask

    task automatic runRandom8(input int n);
        bit got;
        for (int i = 0; i < n; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom); iv8 = 1'b1;
            got = 0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (ir8) got = 1;
                @(posedge clk);
                #1;
                or8 = ($urandom_range(0, 3) != 0);
                if (got) break;
            end
            if (!got) begin
                failNow("dut8_random_accept");
                break;
            end
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic runRandom16(input int n);
        bit got;
        for (int i = 0; i < n; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom); iv16 = 1'b1;
            got = 0;
            for (int k = 0; k < 300; k++) begin
                @(negedge clk);
                if (ir16) got = 1;
                @(posedge clk);
                #1;
                or16 = ($urandom_range(0, 3) != 0);
                if (got) break;
            end
            if (!got) begin
                failNow("dut16_random_accept");
                break;
            end
        end
        iv16 = 1'b0;
        or16 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] res;
        int         lat;
        bit         got;

        total = 0; bad = 0; cycle = 0;
        rst = 1'b1;
        iv8 = 0; or8 = 1; a8 = 0; b8 = 0; c8 = 0;
        iv16 = 0; or16 = 1; a16 = 0; b16 = 0; c16 = 0;
        #2;
        checkOutput("reset_in_ready", 32'(ir8), 32'(1));
        checkOutput("reset_out_valid", 32'(ov8), 32'(0));
        checkOutput("reset_busy", 32'(busy8), 32'(0));
        checkOutput("reset_sum_carry", 32'({co8, s8}), 32'(0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus(8'h5A, 8'h3C, 1'b0, res, lat);
        checkOutput("add_5a_3c", 32'(res), 32'h096);
        checkOutput("latency_8", 32'(lat), 32'(8));
        applyStimulus(8'hFF, 8'h01, 1'b0, res, lat);
        checkOutput("add_ff_01", 32'(res), 32'h100);
        applyStimulus(8'hFF, 8'hFF, 1'b1, res, lat);
        checkOutput("add_ff_ff_c1", 32'(res), 32'h1FF);
        applyStimulus(8'h00, 8'h00, 1'b1, res, lat);
        checkOutput("add_00_00_c1", 32'(res), 32'h001);

        // Backpressure: hold the result while new operands knock on the door.
        @(posedge clk);
        #1;
        or8 = 1'b0;
        applyStimulus(8'h12, 8'h34, 1'b0, res, lat);
        checkOutput("add_12_34", 32'(res), 32'h046);
        @(posedge clk);
        #1;
        a8 = 8'h01; b8 = 8'h01; c8 = 1'b0; iv8 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_in_ready_low", 32'(ir8), 32'(0));
            checkOutput("bp_out_valid_held", 32'(ov8), 32'(1));
            checkOutput("bp_sum_held", 32'({co8, s8}), 32'h046);
            @(posedge clk);
            #1;
        end
        or8 = 1'b1;
        got = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ir8) begin
                got = 1;
                break;
            end
        end
        if (!got) failNow("bp_accept_after_release");
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        waitOut8(res);
        checkOutput("add_01_01", 32'(res), 32'h002);

        // Abort an operation three cycles into RUN.
        @(posedge clk);
        #1;
        a8 = 8'hAB; b8 = 8'hCD; c8 = 1'b1; iv8 = 1'b1;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midrun_busy", 32'(busy8), 32'(1));
        rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", 32'(ov8), 32'(0));
        checkOutput("abort_busy", 32'(busy8), 32'(0));
        checkOutput("abort_in_ready", 32'(ir8), 32'(1));
        checkOutput("abort_sum_carry", 32'({co8, s8}), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(8'h80, 8'h80, 1'b0, res, lat);
        checkOutput("add_80_80", 32'(res), 32'h100);
        @(posedge clk);
        #1;

        fork
            runRandom8(1000);
            runRandom16(1000);
        join

        checkOutput("dut8_drained", 32'(exp8.size()), 32'(0));
        checkOutput("dut16_drained", 32'(exp16.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder built around the team's single-bit `full_adder` cell, which it instantiates as its datapath. It accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake. It then feeds one bit pair per clock, LSB first, through the `full_adder`, registering the carry between cycles. It returns the WIDTH-bit sum and the final carry through a second valid/ready handshake.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range is WIDTH >= 2.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands on a_in/b_in/c_in are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- c_in  input  1  carry-in for bit 0.
- out_valid  output  1  sum_out/carry_out hold a completed result.
- out_ready  input  1  downstream accepts the result.
- sum_out  output  WIDTH  A + B + c_in, modulo 2^WIDTH.
- carry_out  output  1  carry out of bit WIDTH-1.
- busy  output  1  high whenever state is not IDLE.

## Operation
- Internal state:
  - shift registers a_sr and b_sr, WIDTH bits each.
  - sum shift register s_sr, WIDTH bits.
  - carry flip-flop cy.
  - bit counter cnt, $clog2(WIDTH) bits.
  - FSM with states IDLE, RUN and DONE.
- Datapath: one `full_adder` instance with inputs a=a_sr[0], b=b_sr[0], c=cy.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: a_sr<=a_in, b_sr<=b_in, cy<=c_in, cnt<=0, then go to RUN.
- RUN, once per cycle:
  - s_sr <= {fa_sum, s_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right by 1, with zero fill.
  - cy <= fa_carry.
  - cnt <= cnt+1.
  - When cnt==WIDTH-1 on that edge, go to DONE.
- DONE:
  - out_valid=1; sum_out=s_sr; carry_out=cy.
  - On out_ready, return to IDLE.
  - sum_out and carry_out hold stable while out_valid=1 and out_ready=0.
- sum_out, carry_out and out_valid are driven directly from registers. sum_out and carry_out are meaningful only while out_valid=1; during RUN they show partial values.
- in_valid outside IDLE is ignored. No operand is latched, and the upstream stage must hold its data.
- out_ready outside DONE is ignored.
- Arithmetic: {carry_out, sum_out} == a_in + b_in + c_in, computed at WIDTH+1 bits, with no overflow lost.
- Reset, asserted at any time including mid-RUN or mid-DONE:
  - State goes to IDLE immediately and the in-flight operation is aborted and discarded.
  - All registers clear to 0: a_sr, b_sr, s_sr, cy, cnt.
  - Output reset values: in_ready=1, out_valid=0, busy=0, sum_out=0, carry_out=0.
  - After rst deasserts, the first accept can occur on the next rising edge.

## Timing
- Acceptance edge E0 is the edge where in_valid&&in_ready=1.
- RUN occupies edges E1 through EWIDTH, one result bit per edge.
- out_valid rises after edge EWIDTH, so latency from acceptance to out_valid is exactly WIDTH cycles.
- A handshake at edge Ed, where out_valid&&out_ready=1, returns the FSM to IDLE; in_ready is 1 in the cycle after Ed.
- Minimum initiation interval is WIDTH+2 cycles: one IDLE cycle, WIDTH RUN cycles, and one DONE cycle with out_ready held high.
- There is no combinational path from in_valid to in_ready or from out_ready to out_valid.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, c_in=0, out_ready=1 -> sum_out=0x96, carry_out=0; out_valid rises exactly 8 cycles after acceptance.
- a=0xFF, b=0x01, c_in=0 -> sum_out=0x00, carry_out=1.
- a=0xFF, b=0xFF, c_in=1 -> sum_out=0xFF, carry_out=1.
- a=0x00, b=0x00, c_in=1 -> sum_out=0x01, carry_out=0.
- Backpressure: a=0x12, b=0x34, with out_ready held 0 for 5 cycles after out_valid rises -> sum_out=0x46 stays stable and out_valid stays 1. Drive in_valid with new operands 0x01/0x01 during this window -> they are not accepted and in_ready=0. After out_ready=1 -> IDLE, then 0x01+0x01 is accepted and gives 0x02.
- Reset mid-RUN: assert rst 3 cycles into an 8-bit add -> immediately out_valid=0, busy=0, in_ready=1, sum_out=0. Release rst and issue 0x80+0x80 -> sum_out=0x00, carry_out=1, with no residue from the aborted operation.
- Randomized back-to-back stream of 1000 operations at WIDTH=8 and WIDTH=16 -> every result matches a reference model of a+b+c_in, and the interval between consecutive acceptances is never less than WIDTH+2 cycles.
